// File: rtl/fpu_pkg.sv
// fpu_pkg
// Shared definitions for the FPU issue path.
//   WB_LATENCY_DEF : default cycles from FPU issue to float-register write
//   FP_NOP         : instruction word driven to the FPU when nothing issues
//   busy_w()       : busy-counter width needed to hold a given latency
//   BUSY_W         : busy-counter width for the default latency
//   fp_op_t        : decoded instruction record kept in the hold register
package fpu_pkg;

  localparam int          WB_LATENCY_DEF = 5;
  localparam logic [31:0] FP_NOP         = 32'h0000_0013;

  function automatic int busy_w(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

  localparam int BUSY_W = busy_w(WB_LATENCY_DEF);

  typedef struct packed {
    logic [31:0] inst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rs1_use;
    logic        rs2_use;
    logic        rd_write;
  } fp_op_t;

endpackage

// File: rtl/fpu_busy_table.sv
// fpu_busy_table
// 32-entry table of float-register busy counters. A counter is loaded with
// LATENCY when an instruction writing that register issues, and every other
// nonzero counter counts down by one per cycle until the writeback lands.
// Ports:
//   clk, rst          clock, asynchronous active-high reset (clears all)
//   ld_en, ld_idx     load counter[ld_idx] with LATENCY this edge
//   rd_idx_a/b        combinational read addresses (source registers)
//   cnt_a/b           counter values before the coming edge
module fpu_busy_table
  import fpu_pkg::*;
#(
  parameter int LATENCY = WB_LATENCY_DEF,
  parameter int CNT_W   = busy_w(LATENCY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_en,
  input  logic [4:0]       ld_idx,
  input  logic [4:0]       rd_idx_a,
  input  logic [4:0]       rd_idx_b,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY);

  logic [CNT_W-1:0] cnt_q [32];

  // A load overrides the decrement, so a second writer to a busy register
  // restarts its countdown rather than extending it (single shared latency).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (ld_en && (ld_idx == 5'(i))) cnt_q[i] <= LOAD_VAL;
        else if (cnt_q[i] != '0)        cnt_q[i] <= cnt_q[i] - CNT_W'(1);
      end
    end
  end

  assign cnt_a = cnt_q[rd_idx_a];
  assign cnt_b = cnt_q[rd_idx_b];

endmodule

// File: rtl/fpu_issue_scoreboard.sv
// fpu_issue_scoreboard
// Holds one decoded FP instruction and releases it to the FPU only when none
// of its float sources is still waiting on an in-flight writeback.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   in_valid / in_ready        offer / accept handshake from the front end
//   in_inst                    instruction word (rs1 [19:15], rs2 [24:20], rd [11:7])
//   in_frs1_use, in_frs2_use   instruction reads float rs1 / rs2
//   in_frd_write               instruction writes float rd
//   flush                      drop the held, not-yet-issued instruction
//   out_inst, out_valid        word to the FPU (NOP when not issuing), issue strobe
//   stall_cnt                  saturating count of hazard-stall cycles
// Build option:
//   FREG_BYPASS_EN  register file writes through, so a dependent may issue in
//                   the writeback cycle itself (hazard only while counter > 1).
module fpu_issue_scoreboard
  import fpu_pkg::*;
#(
  parameter int WB_LATENCY = WB_LATENCY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic        in_frs1_use,
  input  logic        in_frs2_use,
  input  logic        in_frd_write,
  input  logic        flush,
  output logic [31:0] out_inst,
  output logic        out_valid,
  output logic [15:0] stall_cnt
);

  localparam int CNT_W = busy_w(WB_LATENCY);

`ifdef FREG_BYPASS_EN
  localparam logic [CNT_W-1:0] HAZ_TH = CNT_W'(1);
`else
  localparam logic [CNT_W-1:0] HAZ_TH = CNT_W'(0);
`endif

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  fp_op_t           op_in;
  fp_op_t           op_p0;
  logic             vld_p0;
  logic             accept;
  logic             hazard;
  logic             issue;
  logic [CNT_W-1:0] cnt_rs1;
  logic [CNT_W-1:0] cnt_rs2;
  logic [15:0]      stall_q;

  always_comb begin
    op_in          = '0;
    op_in.inst     = in_inst;
    op_in.rs1      = in_inst[19:15];
    op_in.rs2      = in_inst[24:20];
    op_in.rd       = in_inst[11:7];
    op_in.rs1_use  = in_frs1_use;
    op_in.rs2_use  = in_frs2_use;
    op_in.rd_write = in_frd_write;
  end

  // The slot frees up in the same cycle its occupant issues, which is what
  // allows one issue per cycle with no bubbles.
  assign in_ready = !flush && (!vld_p0 || issue);
  assign accept   = in_valid && in_ready;

  // ---- stage p0: hold register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 vld_p0 <= 1'b0;
    else if (accept)         vld_p0 <= 1'b1;
    else if (issue || flush) vld_p0 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (accept) op_p0 <= op_in;
  end

  // Sources are checked against counters as they stand before the issue
  // edge, so an instruction never hazards on its own destination.
  fpu_busy_table #(
    .LATENCY (WB_LATENCY),
    .CNT_W   (CNT_W)
  ) u_busy (
    .clk      (clk),
    .rst      (rst),
    .ld_en    (issue && op_p0.rd_write),
    .ld_idx   (op_p0.rd),
    .rd_idx_a (op_p0.rs1),
    .rd_idx_b (op_p0.rs2),
    .cnt_a    (cnt_rs1),
    .cnt_b    (cnt_rs2)
  );

  assign hazard = (op_p0.rs1_use && (cnt_rs1 > HAZ_TH)) ||
                  (op_p0.rs2_use && (cnt_rs2 > HAZ_TH));
  assign issue  = vld_p0 && !hazard && !flush;

  // ---- stage p0 -> FPU: issue outputs ----
  assign out_valid = issue;
  assign out_inst  = issue ? op_p0.inst : FP_NOP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            stall_q <= 16'd0;
    else if (vld_p0 && hazard && !flush) stall_q <= sat_inc16(stall_q);
  end

  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_fpu_issue_scoreboard.sv
// tb_fpu_issue_scoreboard
// Directed scenarios against fpu_issue_scoreboard with WB_LATENCY = 5, plus a
// second instance with a long latency used to saturate the stall counter.
// Expected values follow the FREG_BYPASS_EN setting of the build.
module tb_fpu_issue_scoreboard;

`ifdef FREG_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = 32'd0;
  logic        in_frs1_use = 1'b0;
  logic        in_frs2_use = 1'b0;
  logic        in_frd_write = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] out_inst;
  logic        out_valid;
  logic [15:0] stall_cnt;

  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic [31:0] in_inst2 = 32'd0;
  logic        use2 = 1'b0;
  logic [31:0] out_inst2;
  logic        out_valid2;
  logic [15:0] stall_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpu_issue_scoreboard #(.WB_LATENCY(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_frs1_use(in_frs1_use), .in_frs2_use(in_frs2_use),
    .in_frd_write(in_frd_write), .flush(flush), .out_inst(out_inst),
    .out_valid(out_valid), .stall_cnt(stall_cnt)
  );

  fpu_issue_scoreboard #(.WB_LATENCY(255)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_inst(in_inst2), .in_frs1_use(use2), .in_frs2_use(use2),
    .in_frd_write(use2), .flush(1'b0), .out_inst(out_inst2),
    .out_valid(out_valid2), .stall_cnt(stall_cnt2)
  );

  function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b0, rd, 7'h53};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] i, input logic a,
                        input logic b, input logic w);
    in_valid = v; in_inst = i; in_frs1_use = a; in_frs2_use = b; in_frd_write = w;
  endtask

  task automatic test_reset();
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (out_inst !== NOP) begin errors++; $display("FAIL reset_out_inst got %h want %h", out_inst, NOP); end
    checks++;
    if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall got %h want 0", stall_cnt); end
    cyc();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++;
    if (out_inst !== NOP) begin errors++; $display("FAIL post_reset_out_inst got %h want %h", out_inst, NOP); end
  endtask

  // fadd f3<-f1,f2 issues at cycle 10; fmul f4<-f3,f3 waits for writeback.
  task automatic test_raw();
    logic [31:0] fadd;
    logic [31:0] fmul;
    int t;
    int issue_t;
    fadd = mk(5'd3, 5'd1, 5'd2);
    fmul = mk(5'd4, 5'd3, 5'd3);
    issue_t = -1;
    cyc(); set_in(1'b1, fadd, 1'b1, 1'b1, 1'b1);          // cycle 9
    cyc(); set_in(1'b1, fmul, 1'b1, 1'b1, 1'b1);          // cycle 10
    @(negedge clk);
    checks++;
    if (out_inst !== fadd) begin errors++; $display("FAIL raw_fadd_issue got %h want %h", out_inst, fadd); end
    cyc(); set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    t = 11;
    while (t < 30) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        issue_t = t;
        break;
      end
      if (t == 11) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall_in_ready got %b want 0", in_ready); end
      end
      cyc();
      t++;
    end
    checks++;
    if (issue_t != 16 - BYP) begin errors++; $display("FAIL raw_issue_cycle got %0d want %0d", issue_t, 16 - BYP); end
    checks++;
    if (out_inst !== fmul) begin errors++; $display("FAIL raw_fmul_inst got %h want %h", out_inst, fmul); end
    checks++;
    if (stall_cnt !== 16'(5 - BYP)) begin errors++; $display("FAIL raw_stall_cnt got %0d want %0d", stall_cnt, 5 - BYP); end
    repeat (8) cyc();
  endtask

  task automatic test_back_to_back();
    logic [15:0] s0;
    s0 = stall_cnt;
    cyc(); set_in(1'b1, mk(5'd1, 5'd20, 5'd20), 1'b1, 1'b1, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (i < 8) set_in(1'b1, mk(5'(i + 1), 5'(20 + i), 5'(20 + i)), 1'b1, 1'b1, 1'b1);
      else       set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_%0d got %b want 1", i, out_valid); end
      checks++;
      if (out_inst !== mk(5'(i), 5'(19 + i), 5'(19 + i))) begin
        errors++; $display("FAIL b2b_inst_%0d got %h want %h", i, out_inst, mk(5'(i), 5'(19 + i), 5'(19 + i)));
      end
    end
    cyc();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_tail_valid got %b want 0", out_valid); end
    checks++;
    if (stall_cnt !== s0) begin errors++; $display("FAIL b2b_stall got %0d want %0d", stall_cnt, s0); end
    repeat (8) cyc();
  endtask

  // Writers to f5 at cycles 10 and 12; the reader waits for the second one.
  task automatic test_waw();
    logic [31:0] wa;
    logic [31:0] wb;
    logic [31:0] rd;
    logic [15:0] s0;
    int t;
    int issue_t;
    wa = mk(5'd5, 5'd1, 5'd2);
    wb = mk(5'd5, 5'd9, 5'd10);
    rd = mk(5'd11, 5'd5, 5'd5);
    issue_t = -1;
    cyc(); set_in(1'b1, wa, 1'b1, 1'b1, 1'b1);            // cycle 9
    cyc(); set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);         // cycle 10
    @(negedge clk);
    checks++;
    if (out_inst !== wa) begin errors++; $display("FAIL waw_first_issue got %h want %h", out_inst, wa); end
    cyc(); set_in(1'b1, wb, 1'b1, 1'b1, 1'b1);            // cycle 11
    cyc(); set_in(1'b1, rd, 1'b1, 1'b1, 1'b1);            // cycle 12
    @(negedge clk);
    checks++;
    if (out_inst !== wb) begin errors++; $display("FAIL waw_second_issue got %h want %h", out_inst, wb); end
    s0 = stall_cnt;
    cyc(); set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    t = 13;
    while (t < 30) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        issue_t = t;
        break;
      end
      cyc();
      t++;
    end
    checks++;
    if (issue_t != 18 - BYP) begin errors++; $display("FAIL waw_reader_cycle got %0d want %0d", issue_t, 18 - BYP); end
    checks++;
    if (stall_cnt !== s0 + 16'(5 - BYP)) begin
      errors++; $display("FAIL waw_stall got %0d want %0d", stall_cnt, s0 + 16'(5 - BYP));
    end
    repeat (8) cyc();
  endtask

  // Reader of f6 stalls, is flushed at cycle 13; f6 keeps counting down.
  task automatic test_flush();
    logic [31:0] w;
    logic [31:0] r;
    logic [31:0] r2;
    logic [15:0] s0;
    int t;
    int issue_t;
    w  = mk(5'd6, 5'd1, 5'd2);
    r  = mk(5'd12, 5'd6, 5'd6);
    r2 = mk(5'd13, 5'd6, 5'd7);
    issue_t = -1;
    cyc(); set_in(1'b1, w, 1'b1, 1'b1, 1'b1);             // cycle 9
    cyc(); set_in(1'b1, r, 1'b1, 1'b1, 1'b1);             // cycle 10
    cyc(); set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);         // cycle 11
    @(negedge clk);
    s0 = stall_cnt;
    cyc();                                                // cycle 12
    cyc(); flush = 1'b1;                                  // cycle 13
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
    cyc(); flush = 1'b0;                                  // cycle 14
    set_in(1'b1, r2, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_next_in_ready got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped got %b want 0", out_valid); end
    checks++;
    if (stall_cnt !== s0 + 16'd2) begin errors++; $display("FAIL flush_stall got %0d want %0d", stall_cnt, s0 + 16'd2); end
    cyc(); set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    t = 15;
    while (t < 30) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        issue_t = t;
        break;
      end
      cyc();
      t++;
    end
    checks++;
    if (issue_t != 16 - BYP) begin errors++; $display("FAIL flush_counter_cycle got %0d want %0d", issue_t, 16 - BYP); end
    checks++;
    if (out_inst !== r2) begin errors++; $display("FAIL flush_r2_inst got %h want %h", out_inst, r2); end
    repeat (8) cyc();
  endtask

  // Reset lands mid-stall with f3 busy; nothing survives it.
  task automatic test_async_reset();
    logic [31:0] w;
    logic [31:0] r;
    w = mk(5'd3, 5'd1, 5'd2);
    r = mk(5'd14, 5'd3, 5'd3);
    cyc(); set_in(1'b1, w, 1'b1, 1'b1, 1'b1);             // cycle 9
    cyc(); set_in(1'b1, r, 1'b1, 1'b1, 1'b1);             // cycle 10
    cyc(); set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);         // cycle 11
    @(negedge clk);
    checks++;
    if (stall_cnt === 16'd0) begin errors++; $display("FAIL areset_pre_stall got %0d want nonzero", stall_cnt); end
    cyc();                                                // cycle 12
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_inst !== NOP) begin errors++; $display("FAIL areset_out_inst got %h want %h", out_inst, NOP); end
    checks++;
    if (stall_cnt !== 16'd0) begin errors++; $display("FAIL areset_stall got %0d want 0", stall_cnt); end
    cyc(); rst = 1'b0;                                    // cycle 13
    set_in(1'b1, r, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_held_dropped got %b want 0", out_valid); end
    cyc(); set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);         // cycle 14
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_reader_issue got %b want 1", out_valid); end
    checks++;
    if (stall_cnt !== 16'd0) begin errors++; $display("FAIL areset_reader_stall got %0d want 0", stall_cnt); end
    repeat (8) cyc();
  endtask

  // Chain of f3<-f3,f3 on the 255-cycle instance: 255 stalls per 256 cycles.
  task automatic test_stall_saturate();
    for (int i = 0; i < 70300; i++) begin
      cyc();
      if (i == 0) begin
        in_valid2 = 1'b1; in_inst2 = mk(5'd3, 5'd3, 5'd3); use2 = 1'b1;
      end
      if (i == 1 || i == 257) begin
        @(negedge clk);
        if (i == 1) begin
          checks++;
          if (out_inst2 !== mk(5'd3, 5'd3, 5'd3)) begin
            errors++; $display("FAIL sat_first_issue got %h want %h", out_inst2, mk(5'd3, 5'd3, 5'd3));
          end
          checks++;
          if (out_valid2 !== 1'b1 || in_ready2 !== 1'b1) begin
            errors++; $display("FAIL sat_first_hs got %b%b want 11", out_valid2, in_ready2);
          end
        end else begin
          checks++;
          if (stall_cnt2 !== 16'(255 - BYP)) begin
            errors++; $display("FAIL sat_first_round got %0d want %0d", stall_cnt2, 255 - BYP);
          end
        end
      end
    end
    @(negedge clk);
    checks++;
    if (stall_cnt2 !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h want ffff", stall_cnt2); end
    in_valid2 = 1'b0; use2 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_raw();
    test_back_to_back();
    test_waw();
    test_flush();
    test_async_reset();
    test_stall_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_issue_scoreboard.md
FPU_ISSUE_SCOREBOARD -- requirements
Module: fpu_issue_scoreboard

Interface
REQ-001 SHALL have parameter: WB_LATENCY, 5, cycles from FPU issue to float-register write (FPU stage-4 writeback).
REQ-002 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  front end offers an FP instruction.
REQ-005 SHALL have port: in_ready  output  1  block accepts the offered instruction this cycle.
REQ-006 SHALL have port: in_inst  input  32  instruction word (rs1 [19:15], rs2 [24:20], rd [11:7]).
REQ-007 SHALL have port: in_frs1_use / in_frs2_use / in_frd_write  input  1 each  decoded float rs1 read, float rs2 read, float rd write.
REQ-008 SHALL have port: flush  input  1  discard held, not-yet-issued instruction.
REQ-009 SHALL have port: out_inst  output  32  instruction word driven to FPU inst input; NOP when not issuing.
REQ-010 SHALL have port: out_valid  output  1  out_inst is a real issue this cycle.
REQ-011 SHALL have port: stall_cnt  output  16  saturating count of hazard-stall cycles.

Function
REQ-012 SHALL hold one instruction (word, rs1, rs2, rd, use flags) in a hold register; hold loaded on the edge where in_valid && in_ready.
REQ-013 SHALL drive in_ready = !flush && (!held_valid || issue).
REQ-014 SHALL keep a per-register busy counter (32 entries, width ceil(log2(WB_LATENCY+1))).
REQ-015 SHALL assert hazard when held rs1 (if frs1_use) or held rs2 (if frs2_use) has a busy counter above the threshold of REQ-027/028.
REQ-016 SHALL compute issue = held_valid && !hazard && !flush, combinationally.
REQ-017 SHALL drive out_inst = held word and out_valid = 1 when issue; otherwise out_inst = NOP (32'h00000013), out_valid = 0.
REQ-018 SHALL, on the issue edge with frd_write, load counter[rd] with WB_LATENCY; every other nonzero counter decrements by 1 per cycle.
REQ-019 SHALL reload (not add to) counter[rd] on a re-issue to a busy rd (WAW; all FPU ops share one writeback latency).
REQ-020 SHALL let the issuing instruction's own sources be checked against pre-edge counter values (issue-time read, no self-hazard).
REQ-021 SHALL treat register f0 like every other register.
REQ-022 SHALL on flush clear held_valid at the next edge, issue nothing that cycle, and leave busy counters counting (in-flight FPU ops are not killable).
REQ-023 SHALL increment stall_cnt each cycle held_valid && hazard && !flush, saturating at 16'hFFFF.
REQ-024 SHALL sustain back-to-back independent issues, one per cycle, with zero bubbles.

Reset
REQ-025 SHALL on rst clear held_valid, all busy counters, and stall_cnt; outputs during and after reset: out_valid 0, out_inst NOP, in_ready 1 once rst deasserts.
REQ-026 SHALL abandon any held or in-flight tracking on reset asserted mid-operation; no counter survives.

Configuration
REQ-027 SHALL, with FREG_BYPASS_EN defined, treat a source as hazarded only when its counter > 1 (register file write-through: a dependent issues in the writeback cycle, issue cycle k -> dependent at k+WB_LATENCY).
REQ-028 SHALL, without FREG_BYPASS_EN, treat a source as hazarded when its counter > 0 (dependent issues at k+WB_LATENCY+1).

Structure
REQ-029 SHALL take WB_LATENCY default, FP_NOP constant, and the busy-counter width from shared package fpu_pkg.
REQ-030 SHALL place the 32-entry counter array with load/decrement/two read ports in sub-module fpu_busy_table.

Verification
REQ-031 SHALL cover: fadd f3<-f1,f2 issued cycle 10, then fmul f4<-f3,f3 held -> no bypass: out_valid for fmul at cycle 16, stall_cnt=5; with FREG_BYPASS_EN at cycle 15, stall_cnt=4.
REQ-032 SHALL cover: 8 independent ops (rd f1..f8, sources f20..f27) in_valid every cycle -> 8 consecutive out_valid cycles, stall_cnt=0.
REQ-033 SHALL cover: writer to f5 at cycle 10, second writer to f5 at cycle 12, reader of f5 -> reader issues no earlier than cycle 18 (no bypass).
REQ-034 SHALL cover: dependent held stalling, flush at cycle 13 -> out_valid 0, held dropped, in_ready 1 cycle 14, counters unchanged.
REQ-035 SHALL cover: rst asserted asynchronously at cycle 12 with f3 busy -> out_inst=32'h00000013 immediately; after release a reader of f3 issues with zero stall.
REQ-036 SHALL cover: forced 70000 hazard cycles (stuck stall) -> stall_cnt holds 16'hFFFF.
